// File: rtl/complex_ram_reader_pkg.sv
// complex_ram_reader_pkg: shared defaults, FSM state encoding and complex word type
// for the complex-number RAM read streamer.
// Contents: DEF_* default parameters, state_t, cplx_t {re, im, idx}.
package complex_ram_reader_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One streamed word at the default widths: components plus source address.
  typedef struct packed {
    logic [DEF_WIDTH-1:0]  re;
    logic [DEF_WIDTH-1:0]  im;
    logic [DEF_ADDR_W-1:0] idx;
  } cplx_t;

endpackage

// File: rtl/complex_ram_reader_if.sv
// complex_ram_reader_if: RAM read port plus the outgoing valid/ready complex stream.
// RAM side: ramRe/ramAddr out of the reader, ramDataReal/ramDataImag back one cycle later.
// Stream side: outReal/outImag/outIndex/outValid out of the reader, outReady back in.
interface complex_ram_reader_if
  import complex_ram_reader_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              ramRe;
  logic [ADDR_W-1:0] ramAddr;
  logic [WIDTH-1:0]  ramDataReal;
  logic [WIDTH-1:0]  ramDataImag;

  logic [WIDTH-1:0]  outReal;
  logic [WIDTH-1:0]  outImag;
  logic [ADDR_W-1:0] outIndex;
  logic              outValid;
  logic              outReady;

  // Reader side.
  modport master (
    output ramRe, ramAddr,
    input  ramDataReal, ramDataImag,
    output outReal, outImag, outIndex, outValid,
    input  outReady
  );

  // RAM + consumer side.
  modport slave (
    input  ramRe, ramAddr,
    output ramDataReal, ramDataImag,
    input  outReal, outImag, outIndex, outValid,
    output outReady
  );

endinterface

// File: rtl/complex_ram_reader_fifo2.sv
// cplx_fifo2: 2-entry synchronous FIFO for complex words; ports clk, rst, push/push_dat,
// pop/pop_dat (head, combinational), full, empty.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module cplx_fifo2
  import complex_ram_reader_pkg::*;
#(
  parameter type T = cplx_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_dat,
  input  logic pop,
  output T     pop_dat,
  output logic full,
  output logic empty
);

  T           mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       push_ok;
  logic       pop_ok;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  // When full, the slot being popped is the one the write pointer targets.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/complex_ram_reader.sv
// complex_ram_reader: on start, reads count (clamped to DEPTH) sequential RAM entries and
// streams {real, imag, index} over valid/ready; ports clk, rst, start, count, busy, done, bus.
// Latency: start edge t -> ramRe/addr 0 in t+1 -> outValid in t+2; 1 word/cycle when ready.
// Backpressure: reads issue only while buffered + in-flight words < 2, so nothing is dropped.
module complex_ram_reader
  import complex_ram_reader_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  complex_ram_reader_if.master bus
);

  typedef struct packed {
    logic [WIDTH-1:0]  re;
    logic [WIDTH-1:0]  im;
    logic [ADDR_W-1:0] idx;
  } word_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q;       // entries to read this burst
  logic [ADDR_W:0]   issued_q;    // reads issued; low bits are the next address
  logic [ADDR_W:0]   xfer_q;      // words handed to the consumer
  logic              inflight_q;  // RAM data for a read issued last cycle is on the bus
  logic [ADDR_W-1:0] inflight_idx_q;

  logic [ADDR_W:0]   count_clamped;
  logic              accept;
  logic              issue;
  logic [1:0]        occ;
  logic              room;

  word_t             ram_word;
  word_t             fifo_head;
  word_t             head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              out_vld;
  logic              fire;

  assign count_clamped = (count > DEPTH_C) ? DEPTH_C : count;
  assign accept        = (state_q == IDLE) && start;

  // ---------------- output buffer ----------------
  // Returning RAM data falls through to the stream when the FIFO is empty, so the
  // in-flight word counts toward the 2-word budget and full throughput needs no
  // extra storage. A word not consumed on arrival is parked in the FIFO.
  assign ram_word  = '{re: bus.ramDataReal, im: bus.ramDataImag, idx: inflight_idx_q};
  assign head      = fifo_empty ? ram_word : fifo_head;
  assign out_vld   = inflight_q | ~fifo_empty;
  assign fire      = out_vld & bus.outReady;
  assign fifo_push = inflight_q & ~(fifo_empty & bus.outReady);
  assign fifo_pop  = fire & ~fifo_empty;

  assign occ  = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign room = (occ + {1'b0, inflight_q}) < 2'd2;

  cplx_fifo2 #(.T(word_t)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (ram_word),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.outValid = out_vld;
  assign bus.outReal  = out_vld ? head.re  : '0;
  assign bus.outImag  = out_vld ? head.im  : '0;
  assign bus.outIndex = out_vld ? head.idx : '0;

  assign bus.ramRe    = issue;
  assign bus.ramAddr  = issue ? issued_q[ADDR_W-1:0] : '0;

  // ---------------- state and counters ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      issued_q       <= '0;
      xfer_q         <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_idx_q <= issued_q[ADDR_W-1:0];
      end
      if (accept) begin
        cnt_q    <= count_clamped;
        issued_q <= '0;
        xfer_q   <= '0;
      end else begin
        if (issue) issued_q <= issued_q + (ADDR_W+1)'(1);
        if (fire)  xfer_q   <= xfer_q + (ADDR_W+1)'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (count_clamped == '0) ? DONE : READ;
        end
      end
      READ: begin
        busy  = 1'b1;
        issue = room && (issued_q < cnt_q);
        if (issue && (issued_q + (ADDR_W+1)'(1) == cnt_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (fire && (xfer_q + (ADDR_W+1)'(1) == cnt_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_complex_ram_reader.sv
// tb_complex_ram_reader: randomized bursts against a RAM model; expected words are
// queued per burst from the RAM contents and a negedge monitor pops and compares them,
// also checking stall stability, read-issue budget, addresses and done/busy timing.
module tb_complex_ram_reader;
  import complex_ram_reader_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int D = DEF_DEPTH;
  localparam int A = DEF_ADDR_W;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [A:0]   count = '0;
  logic         busy;
  logic         done;

  complex_ram_reader_if #(.WIDTH(W), .ADDR_W(A)) bus ();

  complex_ram_reader #(.WIDTH(W), .DEPTH(D), .ADDR_W(A)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .count (count),
    .busy  (busy),
    .done  (done),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: synchronous read, garbage on the data bus when not reading.
  logic [W-1:0] mem_re [D];
  logic [W-1:0] mem_im [D];
  always @(posedge clk) begin
    if (bus.ramRe) begin
      bus.ramDataReal <= mem_re[bus.ramAddr];
      bus.ramDataImag <= mem_im[bus.ramAddr];
    end else begin
      bus.ramDataReal <= W'($urandom);
      bus.ramDataImag <= W'($urandom);
    end
  end

  // Consumer ready patterns: 0 always, 1 = 1,0,0 repeating, 2 random, 3 never.
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.outReady = 1'b1;
      1:       bus.outReady = (cyc % 3 == 0);
      2:       bus.outReady = 1'($urandom_range(0, 1));
      default: bus.outReady = 1'b0;
    endcase
  end

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endfunction

  // Scoreboard state.
  cplx_t exp_q[$];
  int    exp_n    = 0;
  int    burst_id = 0;

  int    seen_id = 0;
  int    issued, xfers, busy_cyc, first_cyc, done_cyc;
  bit    done_seen, prev_done, prev_stall;
  cplx_t prev_word;

  always @(negedge clk) begin
    cplx_t w;
    cplx_t e;
    if (seen_id != burst_id) begin
      seen_id   = burst_id;
      issued    = 0;
      xfers     = 0;
      busy_cyc  = 0;
      first_cyc = -1;
      done_cyc  = -1;
      done_seen = 1'b0;
    end
    w = {bus.outReal, bus.outImag, bus.outIndex};
    if (rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", longint'(bus.outValid), 1);
        check("stall_data_held", longint'(w), longint'(prev_word));
      end
      if (bus.ramRe) begin
        check("read_budget", longint'((issued - xfers) < 2), 1);
        check("read_addr", longint'(bus.ramAddr), longint'(issued));
        check("read_limit", longint'(issued < exp_n), 1);
        issued++;
      end
      if (bus.outValid && bus.outReady) begin
        check("word_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("word", longint'(w), longint'(e));
        end
        if (first_cyc < 0) first_cyc = cyc;
        xfers++;
      end
      if (done) begin
        check("done_single_cycle", longint'(prev_done), 0);
        check("busy_low_at_done", longint'(busy), 0);
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      if (busy) busy_cyc++;
      prev_done  = done;
      prev_stall = bus.outValid && !bus.outReady;
      prev_word  = w;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_expected(input int nc);
    burst_id++;
    exp_n = nc;
    for (int i = 0; i < nc; i++) begin
      exp_q.push_back('{re: mem_re[i], im: mem_im[i], idx: A'(i)});
    end
  endtask

  task automatic randomize_ram();
    for (int i = 0; i < D; i++) begin
      mem_re[i] = W'($urandom);
      mem_im[i] = W'($urandom);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_outValid"}, longint'(bus.outValid), 0);
    check({tag, "_outWord"}, longint'({bus.outReal, bus.outImag, bus.outIndex}), 0);
    check({tag, "_ramRe"}, longint'(bus.ramRe), 0);
    check({tag, "_ramAddr"}, longint'(bus.ramAddr), 0);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
  endtask

  task automatic run_burst(input int n, input int mode, input bit pulse_again);
    int t;
    int nc;
    int k;
    nc = (n > D) ? D : n;
    load_expected(nc);
    rdy_mode = mode;
    @(posedge clk);
    #1;
    start = 1'b1;
    count = (A+1)'(n);
    t     = cyc;
    tick();
    start = 1'b0;
    if (pulse_again) begin
      tick();
      start = 1'b1;
      count = (A+1)'(3);
      tick();
      start = 1'b0;
    end
    k = 0;
    while (!done_seen && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("done_within_budget", longint'(done_seen), 1);
    if (done_seen) begin
      check("transfer_count", xfers, nc);
      check("scoreboard_drained", exp_q.size(), 0);
      if (mode == 0) begin
        check("done_cycle", done_cyc - t, (nc == 0) ? 1 : nc + 2);
        check("busy_cycles", busy_cyc, (nc == 0) ? 0 : nc + 1);
        if (nc > 0) check("first_word_cycle", first_cyc - t, 2);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    rdy_mode = 0;
    randomize_ram();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_idle_outputs("reset");

    // Basic burst with RAM[i] = (i, -i).
    for (int i = 0; i < D; i++) begin
      mem_re[i] = W'(i);
      mem_im[i] = W'(-i);
    end
    run_burst(4, 0, 1'b0);

    // Back-pressure 1,0,0 pattern.
    randomize_ram();
    run_burst(5, 1, 1'b0);

    // Empty burst.
    run_burst(0, 0, 1'b0);

    // Full depth and over-range count.
    randomize_ram();
    run_burst(16, 0, 1'b0);
    run_burst(20, 0, 1'b0);

    // Start pulsed mid-burst, then a start right after done.
    randomize_ram();
    run_burst(6, 0, 1'b1);
    run_burst(3, 0, 1'b0);

    // Reset while draining with the consumer stalled.
    randomize_ram();
    load_expected(2);
    rdy_mode = 3;
    @(posedge clk);
    #1;
    start = 1'b1;
    count = (A+1)'(2);
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_idle_outputs("mid_reset");
    rst = 1'b0;
    exp_q.delete();
    randomize_ram();
    run_burst(2, 0, 1'b0);

    // Random bursts under random back-pressure.
    for (int r = 0; r < 6; r++) begin
      randomize_ram();
      run_burst($urandom_range(0, 20), 2, 1'b0);
    end

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
